// File: rtl/div_fx.sv
// Fixed-point restoring divider, q = (a << P) / b, one quotient bit per clock, valid/ready on both sides.
// Optional build macro DIV_ROUND_EN adds a guard iteration and rounds half away from zero.
module div_fx #(
  parameter int IN_W   = 16,
  parameter int P      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W+P-1:0] q,
  output logic [IN_W-1:0]   r,
  output logic              dbz,
  output logic              ovf
);

  localparam int N = IN_W + P;
`ifdef DIV_ROUND_EN
  localparam int ITER = N + 1;
`else
  localparam int ITER = N;
`endif
  localparam int CW = $clog2(ITER + 1);

  localparam logic [N:0]   POS_MAX   = {2'b00, {(N-1){1'b1}}};
  localparam logic [N:0]   NEG_MAG   = {2'b01, {(N-1){1'b0}}};
  localparam logic [N-1:0] POS_MAX_Q = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MIN_Q = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] DBZ_Q     = SIGNED ? POS_MAX_Q : {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra magnitude bit so that -2^(IN_W-1) does not wrap.
  function automatic logic [IN_W:0] mag_f(input logic [IN_W-1:0] v, input logic neg);
    logic [IN_W:0] ext;
    ext = {neg, v};
    if (neg) begin
      mag_f = (~ext) + {{IN_W{1'b0}}, 1'b1};
    end else begin
      mag_f = ext;
    end
  endfunction

  state_t          state_r, state_nx_s;
  logic [N-1:0]    dvd_r;
  logic [IN_W:0]   dvs_r;
  logic [IN_W:0]   rem_r;
  logic [N-1:0]    quo_r;
  logic [CW-1:0]   cnt_r;
  logic            sa_r, sb_r;
  logic            out_valid_r;
  logic [N-1:0]    q_r;
  logic [IN_W-1:0] r_r;
  logic            dbz_r, ovf_r;

  logic            sa_s, sb_s, b_zero_s, last_s, guard_it_s, ge_s, grd_s, neg_s;
  logic [IN_W+1:0] rem_sh_s, diff_s;
  logic [IN_W:0]   rem_nx_s;
  logic [N-1:0]    quo_nx_s;
  logic [N:0]      mag_s;
  logic [N-1:0]    q_res_s;
  logic            ovf_res_s;
  logic [IN_W-1:0] r_res_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign r         = r_r;
  assign dbz       = dbz_r;
  assign ovf       = ovf_r;

  assign sa_s     = SIGNED && a[IN_W-1];
  assign sb_s     = SIGNED && b[IN_W-1];
  assign b_zero_s = (b == {IN_W{1'b0}});
  assign last_s   = (cnt_r == CW'(ITER - 1));
`ifdef DIV_ROUND_EN
  assign guard_it_s = (cnt_r == CW'(N));
`else
  assign guard_it_s = 1'b0;
`endif

  // The borrow out of the trial subtraction doubles as the compare result.
  assign rem_sh_s = {rem_r, dvd_r[N-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_r};
  assign ge_s     = ~diff_s[IN_W+1];
  assign rem_nx_s = (ge_s && !guard_it_s) ? diff_s[IN_W:0] : (guard_it_s ? rem_r : rem_sh_s[IN_W:0]);
  assign quo_nx_s = guard_it_s ? quo_r : {quo_r[N-2:0], ge_s};
  assign grd_s    = guard_it_s && ge_s;
  assign neg_s    = sa_r ^ sb_r;
  assign r_res_s  = sa_r ? (IN_W'(0) - rem_nx_s[IN_W-1:0]) : rem_nx_s[IN_W-1:0];

  // Signed result with saturation, evaluated on the final iteration.
  always_comb begin
    mag_s     = {1'b0, quo_nx_s} + (N+1)'(grd_s);
    q_res_s   = mag_s[N-1:0];
    ovf_res_s = 1'b0;
    if (SIGNED) begin
      if (!neg_s && (mag_s > POS_MAX)) begin
        q_res_s   = POS_MAX_Q;
        ovf_res_s = 1'b1;
      end else if (neg_s && (mag_s > NEG_MAG)) begin
        q_res_s   = NEG_MIN_Q;
        ovf_res_s = 1'b1;
      end else if (neg_s) begin
        q_res_s = N'(0) - mag_s[N-1:0];
      end else begin
        q_res_s = mag_s[N-1:0];
      end
    end else if (mag_s[N]) begin
      q_res_s   = {N{1'b1}};
      ovf_res_s = 1'b1;
    end else begin
      q_res_s = mag_s[N-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = b_zero_s ? DONE : RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and result registers; a divide-by-zero result waits one cycle in DONE before out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_r       <= {N{1'b0}};
      dvs_r       <= {(IN_W+1){1'b0}};
      rem_r       <= {(IN_W+1){1'b0}};
      quo_r       <= {N{1'b0}};
      cnt_r       <= {CW{1'b0}};
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      out_valid_r <= 1'b0;
      q_r         <= {N{1'b0}};
      r_r         <= {IN_W{1'b0}};
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dvd_r <= N'(mag_f(a, sa_s)) << P;
            dvs_r <= mag_f(b, sb_s);
            rem_r <= {(IN_W+1){1'b0}};
            quo_r <= {N{1'b0}};
            cnt_r <= {CW{1'b0}};
            sa_r  <= sa_s;
            sb_r  <= sb_s;
            if (b_zero_s) begin
              q_r   <= DBZ_Q;
              r_r   <= a;
              dbz_r <= 1'b1;
              ovf_r <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd_r <= dvd_r << 1;
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            q_r         <= q_res_s;
            r_r         <= r_res_s;
            dbz_r       <= 1'b0;
            ovf_r       <= ovf_res_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fx.sv
// Scoreboard bench for div_fx: an unsigned and a signed instance, directed vectors, decoupled monitor.
module tb_div_fx;
  localparam int IN_W = 16;
  localparam int P    = 8;
  localparam int N    = IN_W + P;
`ifdef DIV_ROUND_EN
  localparam int          LAT    = N + 1;
  localparam logic [23:0] Q_2_3  = 24'h0000AB;
  localparam logic [23:0] Q_M2_3 = 24'hFFFF55;
`else
  localparam int          LAT    = N;
  localparam logic [23:0] Q_2_3  = 24'h0000AA;
  localparam logic [23:0] Q_M2_3 = 24'hFFFF56;
`endif

  typedef struct {
    logic [23:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ordy;
  logic        u_in_valid, s_in_valid;
  logic [15:0] a, b;
  logic        u_in_ready, u_out_valid, u_dbz, u_ovf;
  logic        s_in_ready, s_out_valid, s_dbz, s_ovf;
  logic [23:0] u_q, s_q;
  logic [15:0] u_r, s_r;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t cur[2];
  bit   held[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_fx #(.IN_W(IN_W), .P(P), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .out_valid(u_out_valid), .out_ready(ordy),
    .q(u_q), .r(u_r), .dbz(u_dbz), .ovf(u_ovf)
  );

  div_fx #(.IN_W(IN_W), .P(P), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .out_valid(s_out_valid), .out_ready(ordy),
    .q(s_q), .r(s_r), .dbz(s_dbz), .ovf(s_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // First out_valid cycle pops and checks the full result; later held cycles check stability.
  task automatic mon(input int sel, input logic ov, input logic [23:0] qv, input logic [15:0] rv,
                     input logic dv, input logic fv, input logic irdy);
    exp_t e;
    int   depth;
    depth = (sel == 1) ? sb1.size() : sb0.size();
    if (!rst_n || !ov) begin
      held[sel] = 1'b0;
    end else if (!held[sel]) begin
      if (depth == 0) begin
        chk($sformatf("unexpected_out_valid dut%0d", sel), {31'd0, ov}, 32'd0);
      end else begin
        if (sel == 1) e = sb1.pop_front();
        else          e = sb0.pop_front();
        cur[sel]  = e;
        held[sel] = 1'b1;
        chk($sformatf("q dut%0d", sel),   {8'd0, qv},  {8'd0, e.q});
        chk($sformatf("r dut%0d", sel),   {16'd0, rv}, {16'd0, e.r});
        chk($sformatf("dbz dut%0d", sel), {31'd0, dv}, {31'd0, e.dbz});
        chk($sformatf("ovf dut%0d", sel), {31'd0, fv}, {31'd0, e.ovf});
        chk($sformatf("latency dut%0d", sel), cyc - e.acc, e.lat);
      end
    end else begin
      chk($sformatf("q_hold dut%0d", sel), {8'd0, qv}, {8'd0, cur[sel].q});
      chk($sformatf("in_ready_hold dut%0d", sel), {31'd0, irdy}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, u_out_valid, u_q, u_r, u_dbz, u_ovf, u_in_ready);
    mon(1, s_out_valid, s_q, s_r, s_dbz, s_ovf, s_in_ready);
  end

  task automatic issue(input int sel, input logic [15:0] av, input logic [15:0] bv,
                       input logic [23:0] eq, input logic [15:0] er, input logic ed,
                       input logic eo, input int lat, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!((sel == 1) ? s_in_ready : u_in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("accept_timeout");
      return;
    end
    a = av;
    b = bv;
    if (sel == 1) s_in_valid = 1'b1;
    else          u_in_valid = 1'b1;
    @(posedge clk);
    #1;
    u_in_valid = 1'b0;
    s_in_valid = 1'b0;
    e.q = eq; e.r = er; e.dbz = ed; e.ovf = eo; e.acc = cyc; e.lat = lat;
    if (push) begin
      if (sel == 1) sb1.push_back(e);
      else          sb0.push_back(e);
    end
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((((sel == 1) ? sb1.size() : sb0.size()) != 0 || !((sel == 1) ? s_in_ready : u_in_ready))
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("done_timeout");
  endtask

  task automatic run(input int sel, input logic [15:0] av, input logic [15:0] bv,
                     input logic [23:0] eq, input logic [15:0] er, input logic ed,
                     input logic eo, input int lat);
    issue(sel, av, bv, eq, er, ed, eo, lat, 1'b1);
    wait_done(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0; ordy = 1'b1; u_in_valid = 1'b0; s_in_valid = 1'b0;
    a = 16'd0; b = 16'd0;
    held[0] = 1'b0; held[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst out_valid u", {31'd0, u_out_valid}, 32'd0);
    chk("rst q u",         {8'd0, u_q},          32'd0);
    chk("rst in_ready u",  {31'd0, u_in_ready},  32'd1);
    chk("rst out_valid s", {31'd0, s_out_valid}, 32'd0);
    chk("rst q s",         {8'd0, s_q},          32'd0);
    chk("rst in_ready s",  {31'd0, s_in_ready},  32'd1);
    chk("rst dbz s",       {31'd0, s_dbz},       32'd0);

    // Unsigned instance
    run(0, 16'd7,      16'd2, 24'h000380, 16'd0,      1'b0, 1'b0, LAT);
    run(0, 16'd1,      16'd3, 24'h000055, 16'd1,      1'b0, 1'b0, LAT);
    run(0, 16'd2,      16'd3, Q_2_3,      16'd2,      1'b0, 1'b0, LAT);
    run(0, 16'd5,      16'd0, 24'hFFFFFF, 16'd5,      1'b1, 1'b0, 1);
    run(0, 16'hFFFF,   16'd1, 24'hFFFF00, 16'd0,      1'b0, 1'b0, LAT);

    // Signed instance
    run(1, 16'hFFF9,   16'd3,      24'hFFFDAB, 16'hFFFF, 1'b0, 1'b0, LAT);
    run(1, 16'h8000,   16'hFFFF,   24'h7FFFFF, 16'h0000, 1'b0, 1'b1, LAT);
    run(1, 16'd5,      16'd0,      24'h7FFFFF, 16'd5,    1'b1, 1'b0, 1);
    run(1, 16'd7,      16'hFFFE,   24'hFFFC80, 16'd0,    1'b0, 1'b0, LAT);
    run(1, 16'hFFF9,   16'hFFFD,   24'h000255, 16'hFFFF, 1'b0, 1'b0, LAT);
    run(1, 16'h8000,   16'd1,      24'h800000, 16'd0,    1'b0, 1'b0, LAT);
    run(1, 16'hFFFE,   16'd3,      Q_M2_3,     16'hFFFE, 1'b0, 1'b0, LAT);

    // Backpressure: result must hold for 5 cycles with out_ready low
    ordy = 1'b0;
    issue(0, 16'd7, 16'd2, 24'h000380, 16'd0, 1'b0, 1'b0, LAT, 1'b1);
    n = 0;
    while (!u_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("backpressure_valid_timeout");
    repeat (5) @(negedge clk);
    ordy = 1'b1;
    wait_done(0);

    // Reset at iteration 10 of an in-flight division
    issue(0, 16'd100, 16'd7, 24'd0, 16'd0, 1'b0, 1'b0, LAT, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_rst in_ready",  {31'd0, u_in_ready},  32'd1);
    chk("midrun_rst out_valid", {31'd0, u_out_valid}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (u_out_valid) pulses++;
    end
    chk("midrun_rst no_pulse", pulses, 32'd0);

    run(0, 16'd1, 16'd3, 24'h000055, 16'd1, 1'b0, 1'b0, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
